// File: rtl/conv_3x3_stride1_32.sv
`default_nettype none
// ============================================================================
// Module   : conv_3x3_stride1_32
// Purpose  : 32 independent streaming 3x3 convolution channels (stride 1, no
//            padding) on D x D raster-order images, one shared kernel.
// Revision : 1.0 - initial release
// ============================================================================

// Single-channel engine: two line buffers plus a 3x3 window, registered result.
module conv_3x3_engine #(
  parameter int          D          = 9,
  parameter int          data_width = 32,
  parameter logic [71:0] KERNEL     = 72'h010101010101010101
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [data_width-1:0] pxl_in,
  output logic [data_width-1:0] pxl_out,
  output logic                  valid_out
);

  localparam int CW = $clog2(D);

  logic [CW-1:0]         r_col;
  logic [CW-1:0]         r_row;
  logic [data_width-1:0] r_lb0 [D];   // row r-2
  logic [data_width-1:0] r_lb1 [D];   // row r-1
  logic [data_width-1:0] r_win [3][3];
  logic [data_width-1:0] w_col [3];
  logic [data_width-1:0] w_sum;
  logic                  w_done;

  // Signed 8-bit weight times pixel; only the low data_width bits are kept,
  // which equals the full-width product wrapped to data_width.
  function automatic logic [data_width-1:0] mul_w(input logic [7:0] w,
                                                  input logic [data_width-1:0] p);
    logic [data_width-1:0] w_ext;
    w_ext = {{(data_width-8){w[7]}}, w};
    return w_ext * p;
  endfunction

  // Incoming column (top, middle, bottom) and the completing-window flag.
  always_comb begin
    w_col[0] = r_lb0[r_col];
    w_col[1] = r_lb1[r_col];
    w_col[2] = pxl_in;
    w_done   = valid_in && (r_row >= CW'(2)) && (r_col >= CW'(2));
  end

  // Window sum as it will look after this pixel shifts in.
  always_comb begin
    w_sum = '0;
    for (int a = 0; a < 3; a++) begin
      w_sum = w_sum + mul_w(KERNEL[8*(3*a+0) +: 8], r_win[a][1])
                    + mul_w(KERNEL[8*(3*a+1) +: 8], r_win[a][2])
                    + mul_w(KERNEL[8*(3*a+2) +: 8], w_col[a]);
    end
  end

  // Position counters, line buffers and window advance on each accepted pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
      for (int i = 0; i < D; i++) begin
        r_lb0[i] <= '0;
        r_lb1[i] <= '0;
      end
      for (int a = 0; a < 3; a++) begin
        for (int b = 0; b < 3; b++) begin
          r_win[a][b] <= '0;
        end
      end
    end else if (valid_in) begin
      r_lb0[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= pxl_in;
      for (int a = 0; a < 3; a++) begin
        r_win[a][0] <= r_win[a][1];
        r_win[a][1] <= r_win[a][2];
        r_win[a][2] <= w_col[a];
      end
      if (r_col == CW'(D-1)) begin
        r_col <= '0;
        r_row <= (r_row == CW'(D-1)) ? '0 : r_row + CW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Registered result: strobe for one edge per completed window, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pxl_out   <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= w_done;
      if (w_done) begin
        pxl_out <= w_sum;
      end
    end
  end

endmodule

// Top: 32 engines with flat per-channel ports.
module conv_3x3_stride1_32 #(
  parameter int          D          = 9,
  parameter int          data_width = 32,
  parameter logic [71:0] KERNEL     = 72'h010101010101010101
) (
  input  logic clk,
  input  logic reset,
  input  logic valid_in_1,  valid_in_2,  valid_in_3,  valid_in_4,  valid_in_5,  valid_in_6,  valid_in_7,  valid_in_8,
               valid_in_9,  valid_in_10, valid_in_11, valid_in_12, valid_in_13, valid_in_14, valid_in_15, valid_in_16,
               valid_in_17, valid_in_18, valid_in_19, valid_in_20, valid_in_21, valid_in_22, valid_in_23, valid_in_24,
               valid_in_25, valid_in_26, valid_in_27, valid_in_28, valid_in_29, valid_in_30, valid_in_31, valid_in_32,
  input  logic [data_width-1:0]
               pxl_in_1,  pxl_in_2,  pxl_in_3,  pxl_in_4,  pxl_in_5,  pxl_in_6,  pxl_in_7,  pxl_in_8,
               pxl_in_9,  pxl_in_10, pxl_in_11, pxl_in_12, pxl_in_13, pxl_in_14, pxl_in_15, pxl_in_16,
               pxl_in_17, pxl_in_18, pxl_in_19, pxl_in_20, pxl_in_21, pxl_in_22, pxl_in_23, pxl_in_24,
               pxl_in_25, pxl_in_26, pxl_in_27, pxl_in_28, pxl_in_29, pxl_in_30, pxl_in_31, pxl_in_32,
  output logic [data_width-1:0]
               pxl_out_1,  pxl_out_2,  pxl_out_3,  pxl_out_4,  pxl_out_5,  pxl_out_6,  pxl_out_7,  pxl_out_8,
               pxl_out_9,  pxl_out_10, pxl_out_11, pxl_out_12, pxl_out_13, pxl_out_14, pxl_out_15, pxl_out_16,
               pxl_out_17, pxl_out_18, pxl_out_19, pxl_out_20, pxl_out_21, pxl_out_22, pxl_out_23, pxl_out_24,
               pxl_out_25, pxl_out_26, pxl_out_27, pxl_out_28, pxl_out_29, pxl_out_30, pxl_out_31, pxl_out_32,
  output logic valid_out_1,  valid_out_2,  valid_out_3,  valid_out_4,  valid_out_5,  valid_out_6,  valid_out_7,  valid_out_8,
               valid_out_9,  valid_out_10, valid_out_11, valid_out_12, valid_out_13, valid_out_14, valid_out_15, valid_out_16,
               valid_out_17, valid_out_18, valid_out_19, valid_out_20, valid_out_21, valid_out_22, valid_out_23, valid_out_24,
               valid_out_25, valid_out_26, valid_out_27, valid_out_28, valid_out_29, valid_out_30, valid_out_31, valid_out_32
);

  logic [31:0]                 w_vin;
  logic [31:0]                 w_vout;
  logic [31:0][data_width-1:0] w_pin;
  logic [31:0][data_width-1:0] w_pout;

  assign w_vin = {valid_in_32, valid_in_31, valid_in_30, valid_in_29, valid_in_28, valid_in_27, valid_in_26, valid_in_25,
                  valid_in_24, valid_in_23, valid_in_22, valid_in_21, valid_in_20, valid_in_19, valid_in_18, valid_in_17,
                  valid_in_16, valid_in_15, valid_in_14, valid_in_13, valid_in_12, valid_in_11, valid_in_10, valid_in_9,
                  valid_in_8,  valid_in_7,  valid_in_6,  valid_in_5,  valid_in_4,  valid_in_3,  valid_in_2,  valid_in_1};

  assign w_pin = {pxl_in_32, pxl_in_31, pxl_in_30, pxl_in_29, pxl_in_28, pxl_in_27, pxl_in_26, pxl_in_25,
                  pxl_in_24, pxl_in_23, pxl_in_22, pxl_in_21, pxl_in_20, pxl_in_19, pxl_in_18, pxl_in_17,
                  pxl_in_16, pxl_in_15, pxl_in_14, pxl_in_13, pxl_in_12, pxl_in_11, pxl_in_10, pxl_in_9,
                  pxl_in_8,  pxl_in_7,  pxl_in_6,  pxl_in_5,  pxl_in_4,  pxl_in_3,  pxl_in_2,  pxl_in_1};

  assign {valid_out_32, valid_out_31, valid_out_30, valid_out_29, valid_out_28, valid_out_27, valid_out_26, valid_out_25,
          valid_out_24, valid_out_23, valid_out_22, valid_out_21, valid_out_20, valid_out_19, valid_out_18, valid_out_17,
          valid_out_16, valid_out_15, valid_out_14, valid_out_13, valid_out_12, valid_out_11, valid_out_10, valid_out_9,
          valid_out_8,  valid_out_7,  valid_out_6,  valid_out_5,  valid_out_4,  valid_out_3,  valid_out_2,  valid_out_1} = w_vout;

  assign {pxl_out_32, pxl_out_31, pxl_out_30, pxl_out_29, pxl_out_28, pxl_out_27, pxl_out_26, pxl_out_25,
          pxl_out_24, pxl_out_23, pxl_out_22, pxl_out_21, pxl_out_20, pxl_out_19, pxl_out_18, pxl_out_17,
          pxl_out_16, pxl_out_15, pxl_out_14, pxl_out_13, pxl_out_12, pxl_out_11, pxl_out_10, pxl_out_9,
          pxl_out_8,  pxl_out_7,  pxl_out_6,  pxl_out_5,  pxl_out_4,  pxl_out_3,  pxl_out_2,  pxl_out_1} = w_pout;

  for (genvar g = 0; g < 32; g++) begin : g_ch
    conv_3x3_engine #(
      .D          (D),
      .data_width (data_width),
      .KERNEL     (KERNEL)
    ) u_eng (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (w_vin[g]),
      .pxl_in    (w_pin[g]),
      .pxl_out   (w_pout[g]),
      .valid_out (w_vout[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_3x3_stride1_32.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_3x3_stride1_32
// Purpose  : Directed self-checking bench for conv_3x3_stride1_32 (D=9).
//            dut uses the default all-ones kernel; dut_k uses W[0][0]=-1 only.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_3x3_stride1_32;

  logic        clk = 1'b0;
  logic        reset;
  logic        vin  [32];
  logic [31:0] pin  [32];
  logic [31:0] pout [32];
  logic        vout [32];
  logic [31:0] poutk [32];
  logic        voutk [32];

  int total = 0;
  int bad   = 0;

  // last values seen on strobes, to check that outputs hold between strobes
  logic [31:0] last1, lastk1, last32, lastk32;

  always #5 clk = ~clk;

  conv_3x3_stride1_32 dut (
    .clk(clk), .reset(reset),
    .valid_in_1(vin[0]), .valid_in_2(vin[1]), .valid_in_3(vin[2]), .valid_in_4(vin[3]), .valid_in_5(vin[4]), .valid_in_6(vin[5]), .valid_in_7(vin[6]), .valid_in_8(vin[7]),
    .valid_in_9(vin[8]), .valid_in_10(vin[9]), .valid_in_11(vin[10]), .valid_in_12(vin[11]), .valid_in_13(vin[12]), .valid_in_14(vin[13]), .valid_in_15(vin[14]), .valid_in_16(vin[15]),
    .valid_in_17(vin[16]), .valid_in_18(vin[17]), .valid_in_19(vin[18]), .valid_in_20(vin[19]), .valid_in_21(vin[20]), .valid_in_22(vin[21]), .valid_in_23(vin[22]), .valid_in_24(vin[23]),
    .valid_in_25(vin[24]), .valid_in_26(vin[25]), .valid_in_27(vin[26]), .valid_in_28(vin[27]), .valid_in_29(vin[28]), .valid_in_30(vin[29]), .valid_in_31(vin[30]), .valid_in_32(vin[31]),
    .pxl_in_1(pin[0]), .pxl_in_2(pin[1]), .pxl_in_3(pin[2]), .pxl_in_4(pin[3]), .pxl_in_5(pin[4]), .pxl_in_6(pin[5]), .pxl_in_7(pin[6]), .pxl_in_8(pin[7]),
    .pxl_in_9(pin[8]), .pxl_in_10(pin[9]), .pxl_in_11(pin[10]), .pxl_in_12(pin[11]), .pxl_in_13(pin[12]), .pxl_in_14(pin[13]), .pxl_in_15(pin[14]), .pxl_in_16(pin[15]),
    .pxl_in_17(pin[16]), .pxl_in_18(pin[17]), .pxl_in_19(pin[18]), .pxl_in_20(pin[19]), .pxl_in_21(pin[20]), .pxl_in_22(pin[21]), .pxl_in_23(pin[22]), .pxl_in_24(pin[23]),
    .pxl_in_25(pin[24]), .pxl_in_26(pin[25]), .pxl_in_27(pin[26]), .pxl_in_28(pin[27]), .pxl_in_29(pin[28]), .pxl_in_30(pin[29]), .pxl_in_31(pin[30]), .pxl_in_32(pin[31]),
    .pxl_out_1(pout[0]), .pxl_out_2(pout[1]), .pxl_out_3(pout[2]), .pxl_out_4(pout[3]), .pxl_out_5(pout[4]), .pxl_out_6(pout[5]), .pxl_out_7(pout[6]), .pxl_out_8(pout[7]),
    .pxl_out_9(pout[8]), .pxl_out_10(pout[9]), .pxl_out_11(pout[10]), .pxl_out_12(pout[11]), .pxl_out_13(pout[12]), .pxl_out_14(pout[13]), .pxl_out_15(pout[14]), .pxl_out_16(pout[15]),
    .pxl_out_17(pout[16]), .pxl_out_18(pout[17]), .pxl_out_19(pout[18]), .pxl_out_20(pout[19]), .pxl_out_21(pout[20]), .pxl_out_22(pout[21]), .pxl_out_23(pout[22]), .pxl_out_24(pout[23]),
    .pxl_out_25(pout[24]), .pxl_out_26(pout[25]), .pxl_out_27(pout[26]), .pxl_out_28(pout[27]), .pxl_out_29(pout[28]), .pxl_out_30(pout[29]), .pxl_out_31(pout[30]), .pxl_out_32(pout[31]),
    .valid_out_1(vout[0]), .valid_out_2(vout[1]), .valid_out_3(vout[2]), .valid_out_4(vout[3]), .valid_out_5(vout[4]), .valid_out_6(vout[5]), .valid_out_7(vout[6]), .valid_out_8(vout[7]),
    .valid_out_9(vout[8]), .valid_out_10(vout[9]), .valid_out_11(vout[10]), .valid_out_12(vout[11]), .valid_out_13(vout[12]), .valid_out_14(vout[13]), .valid_out_15(vout[14]), .valid_out_16(vout[15]),
    .valid_out_17(vout[16]), .valid_out_18(vout[17]), .valid_out_19(vout[18]), .valid_out_20(vout[19]), .valid_out_21(vout[20]), .valid_out_22(vout[21]), .valid_out_23(vout[22]), .valid_out_24(vout[23]),
    .valid_out_25(vout[24]), .valid_out_26(vout[25]), .valid_out_27(vout[26]), .valid_out_28(vout[27]), .valid_out_29(vout[28]), .valid_out_30(vout[29]), .valid_out_31(vout[30]), .valid_out_32(vout[31])
  );

  conv_3x3_stride1_32 #(.KERNEL(72'h0000000000000000FF)) dut_k (
    .clk(clk), .reset(reset),
    .valid_in_1(vin[0]), .valid_in_2(vin[1]), .valid_in_3(vin[2]), .valid_in_4(vin[3]), .valid_in_5(vin[4]), .valid_in_6(vin[5]), .valid_in_7(vin[6]), .valid_in_8(vin[7]),
    .valid_in_9(vin[8]), .valid_in_10(vin[9]), .valid_in_11(vin[10]), .valid_in_12(vin[11]), .valid_in_13(vin[12]), .valid_in_14(vin[13]), .valid_in_15(vin[14]), .valid_in_16(vin[15]),
    .valid_in_17(vin[16]), .valid_in_18(vin[17]), .valid_in_19(vin[18]), .valid_in_20(vin[19]), .valid_in_21(vin[20]), .valid_in_22(vin[21]), .valid_in_23(vin[22]), .valid_in_24(vin[23]),
    .valid_in_25(vin[24]), .valid_in_26(vin[25]), .valid_in_27(vin[26]), .valid_in_28(vin[27]), .valid_in_29(vin[28]), .valid_in_30(vin[29]), .valid_in_31(vin[30]), .valid_in_32(vin[31]),
    .pxl_in_1(pin[0]), .pxl_in_2(pin[1]), .pxl_in_3(pin[2]), .pxl_in_4(pin[3]), .pxl_in_5(pin[4]), .pxl_in_6(pin[5]), .pxl_in_7(pin[6]), .pxl_in_8(pin[7]),
    .pxl_in_9(pin[8]), .pxl_in_10(pin[9]), .pxl_in_11(pin[10]), .pxl_in_12(pin[11]), .pxl_in_13(pin[12]), .pxl_in_14(pin[13]), .pxl_in_15(pin[14]), .pxl_in_16(pin[15]),
    .pxl_in_17(pin[16]), .pxl_in_18(pin[17]), .pxl_in_19(pin[18]), .pxl_in_20(pin[19]), .pxl_in_21(pin[20]), .pxl_in_22(pin[21]), .pxl_in_23(pin[22]), .pxl_in_24(pin[23]),
    .pxl_in_25(pin[24]), .pxl_in_26(pin[25]), .pxl_in_27(pin[26]), .pxl_in_28(pin[27]), .pxl_in_29(pin[28]), .pxl_in_30(pin[29]), .pxl_in_31(pin[30]), .pxl_in_32(pin[31]),
    .pxl_out_1(poutk[0]), .pxl_out_2(poutk[1]), .pxl_out_3(poutk[2]), .pxl_out_4(poutk[3]), .pxl_out_5(poutk[4]), .pxl_out_6(poutk[5]), .pxl_out_7(poutk[6]), .pxl_out_8(poutk[7]),
    .pxl_out_9(poutk[8]), .pxl_out_10(poutk[9]), .pxl_out_11(poutk[10]), .pxl_out_12(poutk[11]), .pxl_out_13(poutk[12]), .pxl_out_14(poutk[13]), .pxl_out_15(poutk[14]), .pxl_out_16(poutk[15]),
    .pxl_out_17(poutk[16]), .pxl_out_18(poutk[17]), .pxl_out_19(poutk[18]), .pxl_out_20(poutk[19]), .pxl_out_21(poutk[20]), .pxl_out_22(poutk[21]), .pxl_out_23(poutk[22]), .pxl_out_24(poutk[23]),
    .pxl_out_25(poutk[24]), .pxl_out_26(poutk[25]), .pxl_out_27(poutk[26]), .pxl_out_28(poutk[27]), .pxl_out_29(poutk[28]), .pxl_out_30(poutk[29]), .pxl_out_31(poutk[30]), .pxl_out_32(poutk[31]),
    .valid_out_1(voutk[0]), .valid_out_2(voutk[1]), .valid_out_3(voutk[2]), .valid_out_4(voutk[3]), .valid_out_5(voutk[4]), .valid_out_6(voutk[5]), .valid_out_7(voutk[6]), .valid_out_8(voutk[7]),
    .valid_out_9(voutk[8]), .valid_out_10(voutk[9]), .valid_out_11(voutk[10]), .valid_out_12(voutk[11]), .valid_out_13(voutk[12]), .valid_out_14(voutk[13]), .valid_out_15(voutk[14]), .valid_out_16(voutk[15]),
    .valid_out_17(voutk[16]), .valid_out_18(voutk[17]), .valid_out_19(voutk[18]), .valid_out_20(voutk[19]), .valid_out_21(voutk[20]), .valid_out_22(voutk[21]), .valid_out_23(voutk[22]), .valid_out_24(voutk[23]),
    .valid_out_25(voutk[24]), .valid_out_26(voutk[25]), .valid_out_27(voutk[26]), .valid_out_28(voutk[27]), .valid_out_29(voutk[28]), .valid_out_30(voutk[29]), .valid_out_31(voutk[30]), .valid_out_32(voutk[31])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mode 0: ramp 9r+c, 1: column index, 2: all ones, 3: constant 7
  function automatic logic [31:0] pix(input int mode, input int r, input int c);
    case (mode)
      0:       return 32'(9*r + c);
      1:       return 32'(c);
      2:       return 32'hFFFF_FFFF;
      default: return 32'd7;
    endcase
  endfunction

  // all-ones kernel: sum of the 3x3 window, top-left at (r-2,c-2)
  function automatic logic [31:0] exp_sum(input int mode, input int r, input int c);
    case (mode)
      0:       return 32'(9*(9*(r-2) + (c-2)) + 90);
      1:       return 32'(9*(c-1));
      2:       return 32'hFFFF_FFF7;
      default: return 32'd63;
    endcase
  endfunction

  // W[0][0] = -1 only: minus the top-left pixel
  function automatic logic [31:0] exp_k(input int mode, input int r, input int c);
    return 32'(0) - pix(mode, r-2, c-2);
  endfunction

  task automatic check_all(input logic win, input int mode, input int r, input int c);
    chk("vout1", {31'd0, vout[0]}, {31'd0, win});
    chk("voutk1", {31'd0, voutk[0]}, {31'd0, win});
    chk("vout32", {31'd0, vout[31]}, {31'd0, win});
    chk("voutk32", {31'd0, voutk[31]}, {31'd0, win});
    if (win) begin
      last1 = exp_sum(mode, r, c);
      lastk1 = exp_k(mode, r, c);
      last32 = 32'd45;
      lastk32 = 32'hFFFF_FFFB;
    end
    chk("pout1", pout[0], last1);
    chk("poutk1", poutk[0], lastk1);
    chk("pout32", pout[31], last32);
    chk("poutk32", poutk[31], lastk32);
  endtask

  // One frame on ch1 (mode pattern) and ch32 (constant 5); optional 3-cycle
  // gaps after indices ga/gb; stops after index stop_at when stop_at >= 0.
  task automatic frame(input int mode, input int ga, input int gb, input int stop_at);
    int strobes = 0;
    for (int idx = 0; idx < 81; idx++) begin
      int r = idx / 9;
      int c = idx % 9;
      @(negedge clk);
      vin[0] = 1'b1; pin[0] = pix(mode, r, c);
      vin[31] = 1'b1; pin[31] = 32'd5;
      @(posedge clk); #1;
      check_all((r >= 2) && (c >= 2), mode, r, c);
      if (vout[0]) strobes++;
      if (idx == stop_at) return;
      if (idx == ga || idx == gb) begin
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          vin[0] = 1'b0; vin[31] = 1'b0; pin[0] = 32'hDEAD_BEEF;
          @(posedge clk); #1;
          check_all(1'b0, mode, r, c);
        end
      end
    end
    chk("strobes49", 32'(strobes), 32'd49);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      vin[i] = 1'b0;
      pin[i] = 32'd0;
    end
    last1 = 0; lastk1 = 0; last32 = 0; lastk32 = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      chk("rst_vout", {31'd0, vout[i]}, 32'd0);
      chk("rst_pout", pout[i], 32'd0);
      chk("rst_voutk", {31'd0, voutk[i]}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    // ramp, then 10 more back-to-back ramp frames
    for (int f = 0; f < 11; f++) frame(0, -1, -1, -1);
    // gaps after index 30 and 44
    frame(0, 30, 44, -1);
    // all-ones wrap, constant 7, column-index pattern
    frame(2, -1, -1, -1);
    frame(3, -1, -1, -1);
    frame(1, -1, -1, -1);

    // asynchronous reset mid-frame after index 40
    frame(0, -1, -1, 40);
    chk("pre_rst_pout", pout[0], 32'd90 + 32'd9*32'd20);
    #2 reset = 1'b1;
    #1;
    chk("arst_vout", {31'd0, vout[0]}, 32'd0);
    chk("arst_pout", pout[0], 32'd0);
    chk("arst_pout32", pout[31], 32'd0);
    chk("arst_poutk", poutk[0], 32'd0);
    vin[0] = 1'b0; vin[31] = 1'b0;
    last1 = 0; lastk1 = 0; last32 = 0; lastk32 = 0;
    @(negedge clk);
    reset = 1'b0;
    frame(0, -1, -1, -1);

    // idle channels never produced anything
    @(negedge clk);
    vin[0] = 1'b0; vin[31] = 1'b0;
    for (int i = 1; i < 31; i++) begin
      chk("idle_vout", {31'd0, vout[i]}, 32'd0);
      chk("idle_pout", pout[i], 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
